fdma_vbuf_wr_ctrl: RTL and testbench

- Command sequencer directly upstream of the FDMA AXI4 burst master.
- Issues one write burst per video line: burst address plus burst size, using a req/busy handshake.
- Walks a frame of LINES lines across BUF_NUM rotating frame buffers in DDR.
- Gates each burst on the pixel-FIFO fill level, so the FDMA never underruns its read side.

---
 rtl/fdma_vbuf_wr_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fdma_vbuf_wr_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdma_vbuf_wr_ctrl.sv
// fdma_vbuf_wr_ctrl: per-line write-burst sequencer feeding the FDMA master.
// Optional watchdog enabled by defining FDMA_TIMEOUT_EN.
module fdma_vbuf_wr_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0020_0000,
  parameter logic [31:0] LINE_STRIDE  = 32'h0000_1000,
  parameter int unsigned LINE_WORDS   = 480,
  parameter int unsigned LINES        = 270,
  parameter int unsigned BUF_NUM      = 3,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  fifo_cnt,
  output logic              fdma_req,
  output logic [ADDR_W-1:0] fdma_addr,
  output logic [15:0]       fdma_size,
  input  logic              fdma_busy,
  output logic              frame_done,
  output logic [1:0]        rd_buf,
  output logic              active,
  output logic              start_drop,
  output logic              error
);

  localparam int unsigned LN_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [LN_W-1:0]  LAST_LN  = LN_W'(LINES - 1);
  localparam logic [1:0]       LAST_BUF = 2'(BUF_NUM - 1);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_BUSY,
    S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [LN_W-1:0]   line_q, line_d;
  logic [1:0]        wr_idx_q, wr_idx_d;
  logic [1:0]        rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              start_ok;
  logic [ADDR_W-1:0] addr_calc;

  // Start address of the next line burst, wrapping modulo 2^ADDR_W.
  assign addr_calc = ADDR_W'(BASE_ADDR)
                   + ADDR_W'(wr_idx_q) * ADDR_W'(FRAME_STRIDE)
                   + ADDR_W'(line_q) * ADDR_W'(LINE_STRIDE);

`ifdef FDMA_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign start_ok = (state_q == S_IDLE) && !err_q;
`else
  assign start_ok = (state_q == S_IDLE);
`endif

  // Next-state and registered-output logic of the line sequencer.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    wr_idx_d = wr_idx_q;
    rd_buf_d = rd_buf_q;
    addr_d   = addr_q;
    req_d    = 1'b0;
    done_d   = 1'b0;
    drop_d   = frame_start && !start_ok;
`ifdef FDMA_TIMEOUT_EN
    err_d    = err_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_start && start_ok) begin
          state_d = S_WAIT;
          line_d  = '0;
        end
      end
      S_WAIT: begin
        if (fifo_cnt >= THR) begin
          addr_d  = addr_calc;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (fdma_busy) state_d = S_BUSY;
        else           req_d   = 1'b1;
      end
      S_BUSY: begin
        if (!fdma_busy) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (line_q == LAST_LN) begin
          done_d   = 1'b1;
          rd_buf_d = wr_idx_q;
          wr_idx_d = (wr_idx_q == LAST_BUF) ? 2'd0 : wr_idx_q + 2'd1;
          state_d  = S_IDLE;
        end else begin
          line_d  = line_q + LN_W'(1);
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FDMA_TIMEOUT_EN
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_REQ || state_q == S_BUSY) begin
      if (cnt_q == TMO_LAST) begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        err_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
`endif
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      wr_idx_q <= '0;
      rd_buf_q <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
`ifdef FDMA_TIMEOUT_EN
      err_q    <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      wr_idx_q <= wr_idx_d;
      rd_buf_q <= rd_buf_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
`ifdef FDMA_TIMEOUT_EN
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign fdma_req   = req_q;
  assign fdma_addr  = addr_q;
  assign fdma_size  = 16'(LINE_WORDS);
  assign frame_done = done_q;
  assign rd_buf     = rd_buf_q;
  assign active     = (state_q != S_IDLE);
  assign start_drop = drop_q;
`ifdef FDMA_TIMEOUT_EN
  assign error      = err_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_fdma_vbuf_wr_ctrl.sv
// tb_fdma_vbuf_wr_ctrl: randomized directed bench with a behavioural
// FDMA responder and a frame/address reference model.
module tb_fdma_vbuf_wr_ctrl;

  localparam int LW = 16;
  localparam int NL = 4;
  localparam int NB = 3;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        frame_start;
  logic [11:0] fifo_cnt;
  logic        fdma_req;
  logic [31:0] fdma_addr;
  logic [15:0] fdma_size;
  logic        fdma_busy;
  logic        frame_done;
  logic [1:0]  rd_buf;
  logic        active;
  logic        start_drop;
  logic        error;

  logic        fdma_en;
  logic        model_busy;
  logic        rnd_busy;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int frame_no = 0;
  logic [31:0] got_q[$];

  logic [11:0] f_edge;
  logic        rq_prev = 1'b0;
  logic [31:0] a_prev  = '0;

  assign fdma_busy = fdma_en ? model_busy : rnd_busy;

  always #5 ACLK = ~ACLK;

  fdma_vbuf_wr_ctrl #(
    .ADDR_W      (32),
    .BASE_ADDR   (32'h8000_0000),
    .FRAME_STRIDE(32'h0020_0000),
    .LINE_STRIDE (32'h0000_1000),
    .LINE_WORDS  (LW),
    .LINES       (NL),
    .BUF_NUM     (NB),
    .CNT_W       (12),
    .TIMEOUT     (64)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .frame_start(frame_start),
    .fifo_cnt   (fifo_cnt),
    .fdma_req   (fdma_req),
    .fdma_addr  (fdma_addr),
    .fdma_size  (fdma_size),
    .fdma_busy  (fdma_busy),
    .frame_done (frame_done),
    .rd_buf     (rd_buf),
    .active     (active),
    .start_drop (start_drop),
    .error      (error)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buffer b, line l lives at base + b*frame_stride + l*line_stride.
  function automatic logic [31:0] exp_addr(input int f, input int l);
    return 32'h8000_0000 + 32'(f % NB) * 32'h0020_0000
         + 32'(l) * 32'h0000_1000;
  endfunction

  // Waits for one frame_done, then checks bursts, addresses and rd_buf.
  task automatic wait_frame(input bit rnd);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 2000) begin
      if (rnd) fifo_cnt = 12'($urandom_range(LW - 4, LW + 8));
      tick();
      n++;
    end
    tick();
    chk("frame_done", 32'(done_cnt - d0), 1);
    chk("bursts", 32'(got_q.size()), NL);
    for (int l = 0; l < NL; l++)
      chk("addr", (l < got_q.size()) ? got_q[l] : 32'hx,
          exp_addr(frame_no, l));
    chk("rd_buf", 32'(rd_buf), 32'(frame_no % NB));
    chk("idle", 32'(active), 0);
    frame_no++;
  endtask

  task automatic run_frame(input bit rnd);
    got_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_frame(rnd);
  endtask

  // FDMA responder: busy one cycle after req, held for a random time.
  initial begin
    model_busy = 1'b0;
    forever begin
      tick();
      if (fdma_en && fdma_req && !model_busy) begin
        tick();
        model_busy = 1'b1;
        repeat ($urandom_range(1, 8)) tick();
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: burst capture, FIFO gating, address hold, pulse counts.
  initial begin
    forever begin
      @(posedge ACLK);
      f_edge = fifo_cnt;
      #1;
      if (ARESETN) begin
        if (fdma_req && !rq_prev) begin
          got_q.push_back(fdma_addr);
          chk("gate", 32'(f_edge >= 12'(LW)), 1);
        end
        if (fdma_req && rq_prev) chk("addr_hold", fdma_addr, a_prev);
        if (frame_done) done_cnt++;
        if (start_drop) drop_cnt++;
      end
      rq_prev = fdma_req;
      a_prev  = fdma_addr;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int reqs;
    int dr0;
    ARESETN     = 1'b0;
    frame_start = 1'b0;
    fifo_cnt    = '0;
    rnd_busy    = 1'b0;
    fdma_en     = 1'b0;

    for (int i = 0; i < 6; i++) begin
      frame_start = 1'($urandom);
      fifo_cnt    = 12'($urandom);
      rnd_busy    = 1'($urandom);
      tick();
      chk("rst_out", 32'({fdma_req, frame_done, rd_buf, active,
                          start_drop, error}), 0);
      chk("rst_addr", fdma_addr, 0);
      chk("rst_size", 32'(fdma_size), LW);
    end
    frame_start = 1'b0;
    rnd_busy    = 1'b0;
    fifo_cnt    = 12'(LW);
    ARESETN     = 1'b1;
    fdma_en     = 1'b1;
    tick();

    got_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("lat1_req", 32'(fdma_req), 0);
    chk("lat1_active", 32'(active), 1);
    tick();
    chk("lat2_req", 32'(fdma_req), 1);
    chk("lat2_addr", fdma_addr, 32'h8000_0000);
    wait_frame(1'b0);

    fifo_cnt = 12'(LW - 1);
    got_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    reqs = 0;
    repeat (50) begin
      tick();
      if (fdma_req) reqs++;
    end
    chk("gate_hold", 32'(reqs), 0);
    chk("gate_active", 32'(active), 1);
    fifo_cnt = 12'(LW);
    tick();
    chk("gate_req", 32'(fdma_req), 1);
    wait_frame(1'b1);

    fifo_cnt = 12'(LW);
    got_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    chk("mid_wait", 32'(got_q.size() >= 2), 1);
    ARESETN = 1'b0;
    fdma_en = 1'b0;
    #1;
    chk("mid_rst_rdbuf", 32'(rd_buf), 0);
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_req", 32'(fdma_req), 0);
    repeat (20) tick();
    ARESETN  = 1'b1;
    fdma_en  = 1'b1;
    frame_no = 0;
    tick();

    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 5)) tick();
      run_frame(1'b1);
    end
    chk("no_drop", 32'(drop_cnt), 0);

    fifo_cnt = 12'(LW);
    dr0 = drop_cnt;
    got_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (got_q.size() < 3 && n < 500) begin
      tick();
      n++;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_frame(1'b0);
    chk("overlap_drop", 32'(drop_cnt - dr0), 1);

    fdma_en  = 1'b0;
    rnd_busy = 1'b1;
    fifo_cnt = '0;
    repeat (3) tick();
    chk("busy_idle", 32'(active), 0);
    got_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    chk("busy_wait_act", 32'(active), 1);
    chk("busy_wait_req", 32'(fdma_req), 0);
    rnd_busy = 1'b0;
    fdma_en  = 1'b1;
    fifo_cnt = 12'(LW);
    wait_frame(1'b0);

`ifdef FDMA_TIMEOUT_EN
    fdma_en  = 1'b0;
    rnd_busy = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("tmo_req", 32'(fdma_req), 1);
    repeat (63) tick();
    chk("tmo_req_last", 32'(fdma_req), 1);
    chk("tmo_err_early", 32'(error), 0);
    tick();
    chk("tmo_err", 32'(error), 1);
    chk("tmo_req_drop", 32'(fdma_req), 0);
    chk("tmo_active", 32'(active), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("tmo_drop", 32'(start_drop), 1);
    chk("tmo_stay_idle", 32'(active), 0);
`else
    chk("error_tied", 32'(error), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
